sound_sequencer: RTL and testbench



---
 rtl/sound_pkg.sv | 18 +
 rtl/sound_sequencer_if.sv | 15 +
 rtl/melody_rom.sv | 48 ++++
 rtl/sound_sequencer.sv | 90 +++++++++
 tb/tb_sound_sequencer.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/sound_pkg.sv
// Shared constants and types for the tug-of-war melody sequencer.
// Half-period values assume a 50 MHz clk.
package sound_pkg;

  localparam logic [15:0] HP_A5 = 16'd28409;
  localparam logic [15:0] HP_C6 = 16'd23877;
  localparam logic [15:0] HP_E6 = 16'd18953;
  localparam logic [15:0] HP_G6 = 16'd15944;
  localparam logic [15:0] HP_C7 = 16'd11944;

  localparam int LEN_P1  = 2;
  localparam int LEN_P2  = 2;
  localparam int LEN_WIN = 4;

  typedef enum logic [1:0] {MEL_P1, MEL_P2, MEL_WIN} melody_t;
  typedef enum logic [1:0] {S_IDLE, S_NOTE, S_GAP} state_t;

endpackage

// File: rtl/sound_sequencer_if.sv
// Event inputs and note outputs between game logic, sequencer and tone generator.
interface sound_sequencer_if;
  logic        ev_p1;
  logic        ev_p2;
  logic        ev_win;
  logic        mute;
  logic [15:0] half_period;
  logic        tone_en;
  logic        busy;

  modport master (output ev_p1, ev_p2, ev_win, mute,
                  input  half_period, tone_en, busy);
  modport slave  (input  ev_p1, ev_p2, ev_win, mute,
                  output half_period, tone_en, busy);
endinterface

// File: rtl/melody_rom.sv
// Combinational melody table: (melody, note index) -> half-period and note flags.
module melody_rom
  import sound_pkg::*;
(
  input  melody_t     mel,
  input  logic [1:0]  idx,
  output logic [15:0] half_period,
  output logic        last_note,
  output logic        long_note
);

  always_comb begin
    half_period = '0;
    last_note   = 1'b0;
    long_note   = 1'b0;
    case (mel)
      MEL_P1: begin
        case (idx)
          2'd0:    half_period = HP_A5;
          2'd1:    half_period = HP_E6;
          default: half_period = '0;
        endcase
        last_note = (idx == 2'(LEN_P1 - 1));
      end
      MEL_P2: begin
        case (idx)
          2'd0:    half_period = HP_E6;
          2'd1:    half_period = HP_A5;
          default: half_period = '0;
        endcase
        last_note = (idx == 2'(LEN_P2 - 1));
      end
      MEL_WIN: begin
        case (idx)
          2'd0:    half_period = HP_C6;
          2'd1:    half_period = HP_E6;
          2'd2:    half_period = HP_G6;
          default: half_period = HP_C7;
        endcase
        last_note = (idx == 2'(LEN_WIN - 1));
        // The closing fanfare note rings twice as long.
        long_note = last_note;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sound_sequencer.sv
// Event-driven melody sequencer feeding the square-wave tone generator.
// Win preempts pulls; any accepted event restarts its melody at note 0.
module sound_sequencer
  import sound_pkg::*;
#(
  parameter int NOTE_TICKS = 12_500_000,
  parameter int GAP_TICKS  = 1_250_000
) (
  input logic              clk,
  input logic              rst,
  sound_sequencer_if.slave bus
);

  localparam logic [24:0] NOTE_LD = 25'(NOTE_TICKS - 1);
  localparam logic [24:0] LONG_LD = 25'(2 * NOTE_TICKS - 1);
  localparam logic [24:0] GAP_LD  = 25'(GAP_TICKS - 1);

  state_t      state;
  melody_t     mel, nxt_mel;
  logic [1:0]  idx, nxt_idx;
  logic [24:0] cnt;
  logic [15:0] hp_q;
  logic        last_q;
  logic        start;
  logic [15:0] rom_hp;
  logic        rom_last, rom_long;

  always_comb begin
    start   = 1'b0;
    nxt_mel = mel;
    nxt_idx = idx + 2'd1;
    if (bus.ev_win) begin
      start   = 1'b1;
      nxt_mel = MEL_WIN;
    end else if ((bus.ev_p1 || bus.ev_p2) && !(state != S_IDLE && mel == MEL_WIN)) begin
      start   = 1'b1;
      nxt_mel = bus.ev_p1 ? MEL_P1 : MEL_P2;
    end
    if (start) nxt_idx = '0;
  end

  // Looks up the note about to be entered, either a restart or the next index.
  melody_rom u_rom (
    .mel         (nxt_mel),
    .idx         (nxt_idx),
    .half_period (rom_hp),
    .last_note   (rom_last),
    .long_note   (rom_long)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      mel    <= MEL_P1;
      idx    <= '0;
      cnt    <= '0;
      hp_q   <= '0;
      last_q <= 1'b0;
    end else if (start || (state == S_GAP && cnt == '0)) begin
      state  <= S_NOTE;
      mel    <= nxt_mel;
      idx    <= nxt_idx;
      cnt    <= rom_long ? LONG_LD : NOTE_LD;
      hp_q   <= rom_hp;
      last_q <= rom_last;
    end else begin
      case (state)
        S_NOTE: begin
          if (cnt == '0) begin
            if (last_q) begin
              state <= S_IDLE;
            end else begin
              state <= S_GAP;
              cnt   <= GAP_LD;
            end
          end else begin
            cnt <= cnt - 25'd1;
          end
        end
        S_GAP:   cnt <= cnt - 25'd1;
        default: ;
      endcase
    end
  end

  assign bus.half_period = hp_q;
  assign bus.tone_en     = (state == S_NOTE) && !bus.mute;
  assign bus.busy        = (state != S_IDLE);

endmodule

// File: tb/tb_sound_sequencer.sv
// Directed plus random checks of sound_sequencer against a per-cycle schedule model.
module tb_sound_sequencer;
  localparam int NT = 8;
  localparam int GT = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  sound_sequencer_if bus ();

  sound_sequencer #(.NOTE_TICKS(NT), .GAP_TICKS(GT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: one queue entry per future clock cycle of the running melody.
  int sched_hp[$];
  bit sched_on[$];
  int cur_mel = 0;
  int last_hp = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic load(input int m);
    int notes[4];
    int len;
    case (m)
      0:       begin notes = '{28409, 18953, 0, 0};         len = 2; end
      1:       begin notes = '{18953, 28409, 0, 0};         len = 2; end
      default: begin notes = '{23877, 18953, 15944, 11944}; len = 4; end
    endcase
    sched_hp.delete();
    sched_on.delete();
    cur_mel = m;
    for (int k = 0; k < len; k++) begin
      int dur = (m == 2 && k == len - 1) ? 2 * NT : NT;
      for (int c = 0; c < dur; c++) begin sched_hp.push_back(notes[k]); sched_on.push_back(1'b1); end
      if (k < len - 1)
        for (int c = 0; c < GT; c++) begin sched_hp.push_back(notes[k]); sched_on.push_back(1'b0); end
    end
  endtask

  task automatic model_edge(input bit p1, input bit p2, input bit win);
    bit playing = sched_hp.size() > 0;
    if (win) load(2);
    else if ((p1 || p2) && !(playing && cur_mel == 2)) load(p1 ? 0 : 1);
    else if (playing) begin
      void'(sched_hp.pop_front());
      void'(sched_on.pop_front());
    end
    if (sched_hp.size() > 0) last_hp = sched_hp[0];
  endtask

  task automatic check_outputs();
    bit bsy = sched_hp.size() > 0;
    bit on  = bsy ? sched_on[0] : 1'b0;
    chk("busy", 32'(bus.busy), 32'(bsy));
    chk("half_period", 32'(bus.half_period), 32'(last_hp));
    chk("tone_en", 32'(bus.tone_en), 32'(on && !bus.mute));
  endtask

  // One clock: events currently driven are sampled, then outputs are checked.
  task automatic cyc();
    @(posedge clk);
    model_edge(bus.ev_p1, bus.ev_p2, bus.ev_win);
    #1;
    check_outputs();
    bus.ev_p1  = 1'b0;
    bus.ev_p2  = 1'b0;
    bus.ev_win = 1'b0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Counts busy cycles until idle; an overrun is reported as a failure.
  task automatic run_idle(input int budget, inout int n);
    int b = 0;
    while (bus.busy === 1'b1 && b < budget) begin
      cyc();
      b++;
      if (bus.busy === 1'b1) n++;
    end
    chk("idle_within_budget", 32'(b < budget), 32'd1);
  endtask

  initial begin
    int n;
    bus.ev_p1 = 1'b0; bus.ev_p2 = 1'b0; bus.ev_win = 1'b0; bus.mute = 1'b0;
    #2;
    chk("rst_hp", 32'(bus.half_period), 32'd0);
    chk("rst_tone", 32'(bus.tone_en), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk); rst = 1'b1;
    cycles(3);

    // P1 from idle
    bus.ev_p1 = 1'b1; cyc(); n = 1;
    chk("p1_first_hp", 32'(bus.half_period), 32'd28409);
    run_idle(100, n);
    chk("p1_busy_len", 32'(n), 32'd18);
    cycles(2);

    // simultaneous pulls select P1
    bus.ev_p1 = 1'b1; bus.ev_p2 = 1'b1; cyc();
    chk("both_first_hp", 32'(bus.half_period), 32'd28409);
    n = 1; run_idle(100, n);

    // win preempts P2 in its second note
    bus.ev_p2 = 1'b1; cyc();
    cycles(NT + GT + 2);
    chk("p2_note2_hp", 32'(bus.half_period), 32'd28409);
    bus.ev_win = 1'b1; cyc(); n = 1;
    chk("win_preempt_hp", 32'(bus.half_period), 32'd23877);
    run_idle(200, n);
    chk("win_busy_len", 32'(n), 32'd46);

    // pull dropped during WIN, win restarts WIN
    bus.ev_win = 1'b1; cyc();
    cycles(NT + GT + 2);
    bus.ev_p1 = 1'b1; cyc();
    chk("win_ignores_p1", 32'(bus.half_period), 32'd18953);
    cycles(NT + GT);
    bus.ev_win = 1'b1; cyc();
    chk("win_restart_hp", 32'(bus.half_period), 32'd23877);
    n = 1; run_idle(200, n);
    chk("win_restart_len", 32'(n), 32'd46);

    // muted P2: sequencing unchanged, tone silent
    bus.mute = 1'b1;
    bus.ev_p2 = 1'b1; cyc(); n = 1;
    run_idle(100, n);
    chk("mute_busy_len", 32'(n), 32'd18);
    chk("mute_last_hp", 32'(bus.half_period), 32'd28409);
    bus.mute = 1'b0;

    // async reset in a WIN gap
    bus.ev_win = 1'b1; cyc();
    cycles(NT);
    #1 rst = 1'b0;
    #1;
    chk("arst_hp", 32'(bus.half_period), 32'd0);
    chk("arst_tone", 32'(bus.tone_en), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    sched_hp.delete(); sched_on.delete(); last_hp = 0;
    @(negedge clk); rst = 1'b1;
    cycles(5);

    // random events and mute
    for (int i = 0; i < 600; i++) begin
      int r = $urandom_range(0, 39);
      if (r == 0) bus.ev_win = 1'b1;
      else if (r < 3) bus.ev_p1 = 1'b1;
      else if (r < 5) bus.ev_p2 = 1'b1;
      else if (r == 5) begin bus.ev_p1 = 1'b1; bus.ev_p2 = 1'b1; end
      if ($urandom_range(0, 15) == 0) bus.mute = ~bus.mute;
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end
endmodule
